// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter sharing BRAM port B between m0 (CPU LSU) and m1 (DMA/debug).
// Decodes byte/half/word accesses into word address + lane enables and returns rdata one cycle later.
module bram_portb_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [1:0]            m0_size,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rsp_valid,
  output logic                  m0_rsp_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [1:0]            m1_size,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rsp_valid,
  output logic                  m1_rsp_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  enb,
  output logic [3:0]            web,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dinb,
  input  logic [DATA_WIDTH-1:0] doutb
);

  logic                  last_q, last_d;
  logic                  gnt0, gnt1, any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_size;
  logic [1:0]            sel_off;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  legal;
  logic [3:0]            base_mask;
  logic [DATA_WIDTH-1:0] lane_data;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_owner_q, rsp_owner_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [1:0]            rsp_off_q, rsp_off_d;
  logic [1:0]            rsp_size_q, rsp_size_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rsp_active;

  // last_q = 1 means m1 was granted most recently, so m0 wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = m0_req && (!m1_req || last_q);
      gnt1 = m1_req && (!m0_req || !last_q);
    end
    any_gnt = gnt0 || gnt1;
    last_d  = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    sel_we    = gnt1 ? m1_we    : m0_we;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_size  = gnt1 ? m1_size  : m0_size;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    sel_off   = sel_addr[1:0];
  end

  always_comb begin
    legal     = 1'b0;
    base_mask = 4'b1111;
    case (sel_size)
      2'd0: begin
        legal     = 1'b1;
        base_mask = 4'b0001;
      end
      2'd1: begin
        legal     = !sel_off[0];
        base_mask = 4'b0011;
      end
      2'd2: legal = (sel_off == 2'd0);
      default: legal = 1'b0;
    endcase
  end

  // Replicate narrow write data across all lanes so the lane enables alone select the target bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_data[gi*8 +: 8] = (sel_size == 2'd0) ? sel_wdata[7:0] :
                                  (sel_size == 2'd1) ? sel_wdata[(gi % 2)*8 +: 8] :
                                                       sel_wdata[gi*8 +: 8];
  end

  always_comb begin
    enb   = 1'b0;
    web   = 4'b0000;
    addrb = '0;
    dinb  = '0;
    if (any_gnt) begin
      addrb = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
      dinb  = lane_data;
      if (legal) begin
        enb = 1'b1;
        if (sel_we) begin
          web = base_mask << sel_off;
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = any_gnt;
    rsp_owner_d = gnt1;
    rsp_we_d    = sel_we;
    rsp_off_d   = sel_off;
    rsp_size_d  = sel_size;
    rsp_err_d   = !legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_off_q   <= 2'd0;
      rsp_size_q  <= 2'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_we_q    <= rsp_we_d;
      rsp_off_q   <= rsp_off_d;
      rsp_size_q  <= rsp_size_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Responses are suppressed while rst is held so a grant just before reset never returns.
  always_comb begin
    shifted = doutb >> {rsp_off_q, 3'b000};
    case (rsp_size_q)
      2'd0:    rd_word = DATA_WIDTH'(shifted[7:0]);
      2'd1:    rd_word = DATA_WIDTH'(shifted[15:0]);
      default: rd_word = shifted;
    endcase
    if (rsp_we_q || rsp_err_q) begin
      rd_word = '0;
    end
    rsp_active = rsp_valid_q && !rst;
  end

  always_comb begin
    m0_rsp_valid = rsp_active && !rsp_owner_q;
    m0_rsp_err   = rsp_active && !rsp_owner_q && rsp_err_q;
    m0_rdata     = (rsp_active && !rsp_owner_q) ? rd_word : '0;
    m1_rsp_valid = rsp_active && rsp_owner_q;
    m1_rsp_err   = rsp_active && rsp_owner_q && rsp_err_q;
    m1_rdata     = (rsp_active && rsp_owner_q) ? rd_word : '0;
  end

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Bench for bram_portb_arbiter: BRAM model, byte-level reference memory, directed pins and random traffic.
`timescale 1ns/1ps
module tb_bram_portb_arbiter;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [1:0]    m0_size = '0;
  logic [31:0]   m0_wdata = '0;
  logic          m0_gnt, m0_rsp_valid, m0_rsp_err;
  logic [31:0]   m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [1:0]    m1_size = '0;
  logic [31:0]   m1_wdata = '0;
  logic          m1_gnt, m1_rsp_valid, m1_rsp_err;
  logic [31:0]   m1_rdata;
  logic          enb;
  logic [3:0]    web;
  logic [AW-1:0] addrb;
  logic [31:0]   dinb;
  logic [31:0]   doutb = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_portb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_err(m0_rsp_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_err(m1_rsp_err), .m1_rdata(m1_rdata),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  function automatic logic [31:0] init_word(input int w);
    if (w == 4)  return 32'h44332211;
    if (w == 12) return 32'hDEADBEEF;
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // BRAM port B: registered read, byte-lane writes.
  logic [31:0] bram_mem [0:8191];
  always @(posedge clk) begin
    if (enb) begin
      doutb <= bram_mem[addrb[AW-1:2]];
      for (int b = 0; b < 4; b++)
        if (web[b]) bram_mem[addrb[AW-1:2]][8*b +: 8] <= dinb[8*b +: 8];
    end
  end

  // Reference: flat byte memory updated straight from granted requests.
  logic [7:0] ref_mem [0:32767];
  initial begin
    logic [31:0] t;
    for (int w = 0; w < 8192; w++) begin
      t = init_word(w);
      bram_mem[w] = t;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = t[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        model_last = 1'b1;
  logic        pend_v = 1'b0;
  int          pend_m = 0;
  logic        pend_err = 1'b0;
  logic [31:0] pend_rd = '0;

  always @(negedge clk) begin : cmp
    int          win, off, n;
    logic        we, legal;
    logic [AW-1:0] a;
    logic [1:0]  sz;
    logic [31:0] wd, ed, rd;
    logic [3:0]  ew;
    check("m0_rsp_valid", 32'(m0_rsp_valid), 32'(!rst && pend_v && pend_m == 0));
    check("m1_rsp_valid", 32'(m1_rsp_valid), 32'(!rst && pend_v && pend_m == 1));
    check("m0_rsp_err", 32'(m0_rsp_err), 32'(!rst && pend_v && pend_m == 0 && pend_err));
    check("m1_rsp_err", 32'(m1_rsp_err), 32'(!rst && pend_v && pend_m == 1 && pend_err));
    check("m0_rdata", m0_rdata, (!rst && pend_v && pend_m == 0) ? pend_rd : 32'h0);
    check("m1_rdata", m1_rdata, (!rst && pend_v && pend_m == 1) ? pend_rd : 32'h0);
    if (rst) begin
      check("rst_m0_gnt", 32'(m0_gnt), 0);
      check("rst_m1_gnt", 32'(m1_gnt), 0);
      check("rst_enb", 32'(enb), 0);
      check("rst_web", 32'(web), 0);
      model_last = 1'b1;
      pend_v = 1'b0;
    end else begin
      win = -1;
      if (m0_req && m1_req) win = model_last ? 0 : 1;
      else if (m0_req) win = 0;
      else if (m1_req) win = 1;
      check("m0_gnt", 32'(m0_gnt), 32'(win == 0));
      check("m1_gnt", 32'(m1_gnt), 32'(win == 1));
      if (win < 0) begin
        check("idle_enb", 32'(enb), 0);
        check("idle_web", 32'(web), 0);
        check("idle_addrb", 32'(addrb), 0);
        check("idle_dinb", dinb, 0);
        pend_v = 1'b0;
      end else begin
        we = (win == 0) ? m0_we : m1_we;
        a  = (win == 0) ? m0_addr : m1_addr;
        sz = (win == 0) ? m0_size : m1_size;
        wd = (win == 0) ? m0_wdata : m1_wdata;
        off = int'(a) % 4;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        legal = (sz != 2'd3) && (off % n == 0);
        ew = 4'b0000;
        if (legal && we) for (int k = 0; k < n; k++) ew[off + k] = 1'b1;
        check("enb", 32'(enb), 32'(legal));
        check("web", 32'(web), 32'(ew));
        rd = '0;
        if (legal) begin
          check("addrb", 32'(addrb), 32'(int'(a) - off));
          for (int b = 0; b < 4; b++) ed[8*b +: 8] = wd[8*(b % n) +: 8];
          check("dinb", dinb, ed);
          for (int k = 0; k < n; k++) begin
            if (we) ref_mem[int'(a) + k] = wd[8*k +: 8];
            else rd[8*k +: 8] = ref_mem[int'(a) + k];
          end
        end
        pend_v = 1'b1;
        pend_m = win;
        pend_err = !legal;
        pend_rd = rd;
        model_last = (win == 1);
      end
    end
  end

  task automatic drive(input int m, input logic r, input logic we, input logic [AW-1:0] a,
                       input logic [1:0] sz, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_size = sz; m0_wdata = wd;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_size = sz; m1_wdata = wd;
    end
  endtask

  task automatic rand_req(input int m);
    logic [1:0] sz;
    logic [AW-1:0] a;
    int off;
    sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    if ($urandom_range(0, 7) == 0) off = $urandom_range(0, 3);
    else if (sz == 2'd0) off = $urandom_range(0, 3);
    else if (sz == 2'd1) off = 2 * $urandom_range(0, 1);
    else off = 0;
    a = AW'(4 * $urandom_range(0, 31) + off);
    drive(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, sz, $urandom);
  endtask

  // One transaction for master m; captures port-B signals at grant and the response a cycle later.
  task automatic xact(input int m, input logic we, input logic [AW-1:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, output logic g_enb, output logic [3:0] g_web,
                      output logic [AW-1:0] g_addrb, output logic [31:0] g_dinb,
                      output logic r_v, output logic r_err, output logic [31:0] r_rd);
    bit got = 0;
    g_enb = 0; g_web = 0; g_addrb = 0; g_dinb = 0; r_v = 0; r_err = 0; r_rd = 0;
    drive(m, 1'b1, we, a, sz, wd);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_gnt) || (m == 1 && m1_gnt)) begin
        got = 1;
        g_enb = enb; g_web = web; g_addrb = addrb; g_dinb = dinb;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout m%0d: gnt=0 after 50 cycles, expected gnt=1", m);
    end
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    @(negedge clk);
    r_v   = (m == 0) ? m0_rsp_valid : m1_rsp_valid;
    r_err = (m == 0) ? m0_rsp_err   : m1_rsp_err;
    r_rd  = (m == 0) ? m0_rdata     : m1_rdata;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    drive(1, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic e, v, er, g0, g1;
    logic [3:0] w;
    logic [AW-1:0] ab;
    logic [31:0] di, rd;

    do_reset(3);

    xact(0, 1'b0, 15'h0010, 2'd2, 32'h0, e, w, ab, di, v, er, rd);
    check("t1_enb", 32'(e), 1);
    check("t1_addrb", 32'(ab), 32'h10);
    check("t1_web", 32'(w), 0);
    check("t1_rsp_valid", 32'(v), 1);
    check("t1_rdata", rd, 32'h44332211);
    check("t1_err", 32'(er), 0);

    xact(1, 1'b1, 15'h0023, 2'd0, 32'h000000A5, e, w, ab, di, v, er, rd);
    check("t2_web", 32'(w), 32'b1000);
    check("t2_dinb", di, 32'hA5A5A5A5);
    check("t2_addrb", 32'(ab), 32'h20);
    check("t2_rsp_valid", 32'(v), 1);
    check("t2_rdata", rd, 32'h0);
    xact(1, 1'b0, 15'h0023, 2'd0, 32'h0, e, w, ab, di, v, er, rd);
    check("t2_readback", rd, 32'h000000A5);

    xact(0, 1'b0, 15'h0001, 2'd1, 32'h0, e, w, ab, di, v, er, rd);
    check("ill_half_enb", 32'(e), 0);
    check("ill_half_err", 32'(er), 1);
    check("ill_half_rdata", rd, 32'h0);
    xact(1, 1'b1, 15'h0006, 2'd2, 32'hCAFEF00D, e, w, ab, di, v, er, rd);
    check("ill_word_enb", 32'(e), 0);
    check("ill_word_web", 32'(w), 0);
    check("ill_word_err", 32'(er), 1);
    xact(0, 1'b1, 15'h0008, 2'd3, 32'h12345678, e, w, ab, di, v, er, rd);
    check("ill_size_web", 32'(w), 0);
    check("ill_size_err", 32'(er), 1);
    check("ill_size_rdata", rd, 32'h0);
    for (int i = 0; i < 3; i++) check("ill_mem_unchanged", bram_mem[i], init_word(i));

    xact(0, 1'b0, 15'h0032, 2'd1, 32'h0, e, w, ab, di, v, er, rd);
    check("t5_half_rdata", rd, 32'h0000DEAD);
    xact(0, 1'b0, 15'h0031, 2'd0, 32'h0, e, w, ab, di, v, er, rd);
    check("t5_byte_rdata", rd, 32'h000000BE);

    do_reset(2);
    drive(0, 1'b1, 1'b0, 15'h0010, 2'd2, 32'h0);
    drive(1, 1'b1, 1'b0, 15'h0030, 2'd2, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alt_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
      check("alt_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    drive(1, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    drive(0, 1'b1, 1'b0, 15'h0010, 2'd2, 32'h0);
    @(negedge clk);
    check("rst_pre_gnt", 32'(m0_gnt), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    @(negedge clk);
    check("rst_no_rsp", 32'(m0_rsp_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_no_rsp_late", 32'(m0_rsp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 15'h0010, 2'd2, 32'h0);
    drive(1, 1'b1, 1'b0, 15'h0030, 2'd2, 32'h0);
    @(negedge clk);
    check("post_rst_m0_first", 32'(m0_gnt), 1);
    check("post_rst_m1_wait", 32'(m1_gnt), 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, 2'd0, 32'h0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      @(posedge clk); #1;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, 2'd0, 32'h0);
        drive(1, 1'b0, 1'b0, '0, 2'd0, 32'h0);
      end else begin
        rst = 1'b0;
        if (!m0_req || g0) rand_req(0);
        if (!m1_req || g1) rand_req(1);
      end
    end
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    drive(1, 1'b0, 1'b0, '0, 2'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_portb_arbiter.md
# bram_portb_arbiter

Shares data port B of the 32 KB dual-port BRAM between two requesters: m0, the CPU load/store unit, and m1, the DMA/debug loader. Each cycle it grants at most one request using round-robin arbitration. It converts byte/half/word accesses into a word-aligned BRAM address plus byte-lane write enables, and steers the read data back to the owning requester one cycle later. Port A (instruction fetch) is not touched.

## Interface
Parameters:
- ADDR_WIDTH, 15, byte-address width of the BRAM
- DATA_WIDTH, 32, data width; only 32 is supported

Ports (mN = m0, m1; each port set is duplicated per requester):
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- mN_req  input  1  request; held with its fields stable until mN_gnt
- mN_we  input  1  1 = write, 0 = read
- mN_addr  input  ADDR_WIDTH  byte address
- mN_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- mN_wdata  input  32  write data, LSB-justified
- mN_gnt  output  1  request accepted this cycle (combinational)
- mN_rsp_valid  output  1  response pulse, exactly one per grant
- mN_rsp_err  output  1  access error, qualified by rsp_valid
- mN_rdata  output  32  read data, LSB-justified, zero-extended
- enb  output  1  BRAM port B enable
- web  output  4  BRAM port B byte write enables
- addrb  output  ADDR_WIDTH  BRAM byte address, always with [1:0] = 0
- dinb  output  32  BRAM write data, already lane-steered
- doutb  input  32  BRAM registered read data

## Operation
- Arbitration
  - Only one requester active: it is granted.
  - Both active: the requester not granted most recently wins.
  - Pointer `last` (1 bit) records the most recent grantee. It updates on every grant and holds otherwise. Reset value is 1, so m0 wins the first contention.
- Decode of the granted request (off = addr[1:0])
  - Legal accesses: byte at any offset; half at off ∈ {0, 2}; word at off = 0.
  - Illegal: size 3, or a misaligned half/word.
  - Legal grant: enb = 1, addrb = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Legal write: web = base mask << off, where base mask is byte 0001, half 0011, word 1111.
  - Legal read: web = 0000.
  - dinb: byte → wdata[7:0] replicated ×4; half → wdata[15:0] replicated ×2; word → wdata.
- Illegal grant: still granted, but enb = 0 and web = 0. The response carries rsp_err = 1 and rdata = 0. The BRAM is not accessed.
- No grant: enb = 0, web = 0, addrb = 0, dinb = 0.
- Response pipeline: registers capture {valid, owner, we, off, size, err} on each grant.
  - Next cycle, rsp_valid is driven only on the owner's interface.
  - Read, no error: rdata = (doutb >> 8·off), masked to 8/16/32 bits.
  - Write, or error: rdata = 0.
  - The non-owner's rsp_valid, rsp_err and rdata are all 0.
- Grants are fully pipelined: a new grant is allowed in the same cycle a response is returned. Sustained throughput is 1 access/cycle.

## Timing
- Grant: mN_gnt is combinational from req and `last` in cycle N. enb/web/addrb/dinb are combinational in cycle N and sampled by the BRAM at the end of cycle N.
- Response: mN_rsp_valid, mN_rsp_err and mN_rdata are valid in cycle N+1 (latency 1). rdata is combinational from doutb and the registered off/size.
- Requester rule: a requester must not change addr/we/size/wdata while req = 1 and gnt = 0. It may drop req only after gnt.
- While rst = 1:
  - all gnt, enb and web are 0;
  - response registers clear, so rsp_valid = 0 and rsp_err = 0 in the cycle after rst is sampled;
  - `last` = 1.
- Reset mid-operation: a grant that occurred in the cycle rst is first sampled produces no response. The response for the grant in the cycle before reset is lost as well, since the registers clear.
- Simultaneous events:
  - Same-cycle requests from both masters resolve purely by `last`.
  - A write by m1 and a read by m0 of the same word on consecutive cycles are ordered by grant order; the later read returns the new data.

## Test plan
- Reset, then m0 read word 0x0010 with mem[0x10..0x13] = 11 22 33 44 → cycle 0: gnt, enb = 1, addrb = 0x0010, web = 0; cycle 1: m0_rsp_valid = 1, rdata = 0x44332211, err = 0.
- m1 byte write 0xA5 at 0x0023 → web = 1000, dinb = 0xA5A5A5A5, addrb = 0x0020; next cycle m1_rsp_valid = 1, rdata = 0. A following byte read at 0x0023 returns 0x000000A5.
- Both masters request continuously for 6 cycles → grants alternate m0, m1, m0, m1, m0, m1 (first grant is m0 after reset). Each rsp_valid appears exactly one cycle after its grant on the correct master only.
- m0 half read at 0x0001, then m1 word write at 0x0006, then size 3 → each is granted with enb = 0 and web = 0. Each response has err = 1 and rdata = 0. BRAM contents are unchanged.
- Half read at 0x0032 with word at 0x30 = 0xDEADBEEF → rdata = 0x0000DEAD. Byte read at 0x0031 → 0x000000BE.
- Assert rst in the cycle after an m0 read grant → no m0_rsp_valid appears. After rst is released, simultaneous requests grant m0 first.
